accumulation_buffer: RTL and testbench

Double-buffered output accumulator directly downstream of the systolic array. Consumes the column-skewed partial-sum vector from the bottom MAC row and deskews it internally. Accumulates into one bank (the write bank) across successive passes of a tile, e.g. over the input-channel/filter loop. The other bank (the read bank) is drained by the output/writeback stage; a bank switch swaps the roles.

---
 rtl/accumulation_buffer_pkg.sv | 12 +
 rtl/ofmap_deskew.sv | 75 +++++++
 rtl/accumulation_buffer.sv | 99 +++++++++
 tb/tb_accumulation_buffer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/accumulation_buffer_pkg.sv
// Shared types and constants for the double-buffered output accumulator.
// Lane vectors carry one partial sum per systolic-array column.
package accumulation_buffer_pkg;

  localparam int LANE_DW   = 32;
  localparam int LANES     = 4;
  localparam int LATENCY   = LANES - 1;
  localparam int NUM_BANKS = 2;

  typedef logic [LANES-1:0][LANE_DW-1:0] lane_vec_t;

endpackage

// File: rtl/ofmap_deskew.sv
// Undoes the array's column skew: lane c waits ARRAY_WIDTH-1-c cycles,
// and the write control rides a full ARRAY_WIDTH-1 cycle line beside it.
module ofmap_deskew #(
  parameter int DATA_WIDTH  = 32,
  parameter int ARRAY_WIDTH = 4,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wen_i,
  input  logic [ADDR_WIDTH-1:0]                 wadr_i,
  input  logic                                  first_i,
  input  logic                                  bank_i,
  input  logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] data_i,
  output logic                                  wen_o,
  output logic [ADDR_WIDTH-1:0]                 wadr_o,
  output logic                                  first_o,
  output logic                                  bank_o,
  output logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] data_o
);

  localparam int LAT = ARRAY_WIDTH - 1;
  localparam int CW  = ADDR_WIDTH + 3;

  logic [CW-1:0] ctrl_in;
  logic [CW-1:0] ctrl_out;

  assign ctrl_in = {wen_i, wadr_i, first_i, bank_i};
  assign {wen_o, wadr_o, first_o, bank_o} = ctrl_out;

  generate
    if (LAT == 0) begin : g_ctrl_bypass
      assign ctrl_out = ctrl_in;
    end else begin : g_ctrl
      logic [LAT-1:0][CW-1:0] sr_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sr_q <= '0;
        end else begin
          sr_q[0] <= ctrl_in;
          for (int i = 1; i < LAT; i++) begin
            sr_q[i] <= sr_q[i-1];
          end
        end
      end

      assign ctrl_out = sr_q[LAT-1];
    end

    for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_lane
      localparam int D = LAT - c;

      if (D == 0) begin : g_pass
        assign data_o[c] = data_i[c];
      end else begin : g_dly
        logic [D-1:0][DATA_WIDTH-1:0] sr_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            sr_q <= '0;
          end else begin
            sr_q[0] <= data_i[c];
            for (int i = 1; i < D; i++) begin
              sr_q[i] <= sr_q[i-1];
            end
          end
        end

        assign data_o[c] = sr_q[D-1];
      end
    end
  endgenerate

endmodule

// File: rtl/accumulation_buffer.sv
// Two flop banks: one accumulates deskewed array output, the other drains.
// Writes carry the bank tag from issue time so in-flight data survives a swap.
module accumulation_buffer
  import accumulation_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ARRAY_WIDTH = 4,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wen,
  input  logic [ADDR_WIDTH-1:0]                        wadr,
  input  logic                                         acc_first,
  input  logic signed [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] ofmap_in,
  input  logic                                         switch_banks,
  input  logic                                         ren,
  input  logic [ADDR_WIDTH-1:0]                        radr,
  output logic signed [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] rdata,
  output logic                                         active_bank
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] vec_t;

  logic                  c_wen;
  logic [ADDR_WIDTH-1:0] c_wadr;
  logic                  c_first;
  logic                  c_bank;
  vec_t                  c_data;

  vec_t [NUM_BANKS-1:0][DEPTH-1:0] mem_q;
  vec_t                            cur;
  vec_t                            upd_d;
  vec_t                            rdata_q;
  vec_t                            rdata_d;
  logic                            active_bank_q;
  logic                            active_bank_d;

  ofmap_deskew #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_WIDTH(ARRAY_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_deskew (
    .clk    (clk),
    .rst    (rst),
    .wen_i  (wen),
    .wadr_i (wadr),
    .first_i(acc_first),
    .bank_i (active_bank_q),
    .data_i (ofmap_in),
    .wen_o  (c_wen),
    .wadr_o (c_wadr),
    .first_o(c_first),
    .bank_o (c_bank),
    .data_o (c_data)
  );

  // Flop storage is written at the edge, so a commit in the next cycle
  // already reads the updated entry; no separate bypass is needed.
  always_comb begin
    cur   = mem_q[c_bank][c_wadr];
    upd_d = '0;
    for (int c = 0; c < ARRAY_WIDTH; c++) begin
      upd_d[c] = c_first ? c_data[c] : cur[c] + c_data[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (c_wen) begin
      mem_q[c_bank][c_wadr] <= upd_d;
    end
  end

  always_comb begin
    rdata_d       = rdata_q;
    active_bank_d = active_bank_q ^ switch_banks;
    if (ren) begin
      rdata_d = mem_q[~active_bank_q][radr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q       <= '0;
      active_bank_q <= 1'b0;
    end else begin
      rdata_q       <= rdata_d;
      active_bank_q <= active_bank_d;
    end
  end

  assign rdata       = rdata_q;
  assign active_bank = active_bank_q;

endmodule

// File: tb/tb_accumulation_buffer.sv
// Directed bench for accumulation_buffer: skewed writes, swaps, wrap,
// read/commit collision and mid-flight reset, with hand-computed results.
module tb_accumulation_buffer;
  import accumulation_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wen = 1'b0;
  logic [3:0]  wadr = '0;
  logic        acc_first = 1'b0;
  lane_vec_t   ofmap_in = '0;
  logic        switch_banks = 1'b0;
  logic        ren = 1'b0;
  logic [3:0]  radr = '0;
  lane_vec_t   rdata;
  logic        active_bank;

  lane_vec_t fut [4];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  accumulation_buffer #(
    .DATA_WIDTH (32),
    .ARRAY_WIDTH(4),
    .ADDR_WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wen         (wen),
    .wadr        (wadr),
    .acc_first   (acc_first),
    .ofmap_in    (ofmap_in),
    .switch_banks(switch_banks),
    .ren         (ren),
    .radr        (radr),
    .rdata       (rdata),
    .active_bank (active_bank)
  );

  function automatic lane_vec_t v4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // One clock cycle; column c of a write is scheduled c cycles ahead.
  task automatic cyc(input logic w, input logic [3:0] a, input logic f,
                     input lane_vec_t v, input logic sw,
                     input logic r, input logic [3:0] ra);
    wen          = w;
    wadr         = a;
    acc_first    = f;
    switch_banks = sw;
    ren          = r;
    radr         = ra;
    if (w) begin
      for (int c = 0; c < 4; c++) fut[c][c] = v[c];
    end
    ofmap_in = fut[0];
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) fut[k] = fut[k+1];
    fut[3]       = '0;
    wen          = 1'b0;
    switch_banks = 1'b0;
    ren          = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic f, input lane_vec_t v);
    cyc(1, a, f, v, 0, 0, 0);
  endtask

  task automatic sw();
    cyc(0, 0, 0, '0, 1, 0, 0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(0, 0, 0, '0, 0, 1, a);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) fut[k] = '0;

    idle(2);
    chk("reset_active", 128'(active_bank), 128'(0));
    chk("reset_rdata", rdata, '0);
    rst = 1'b0;
    idle(1);

    // overwrite, visible only after the 3-cycle commit
    wr(3, 1, v4(10, 11, 12, 13));
    idle(1);
    sw();
    rd(3);
    chk("ovw_precommit", rdata, '0);
    rd(3);
    chk("ovw_data", rdata, v4(10, 11, 12, 13));
    chk("ovw_active", 128'(active_bank), 128'(1));

    // back-to-back accumulate into bank 1 entry 0
    wr(0, 1, v4(5, 5, 5, 5));
    wr(0, 0, v4(7, 7, 7, 7));
    wr(0, 0, v4(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE));
    idle(3);
    sw();
    rd(0);
    chk("acc_data", rdata, v4(10, 10, 10, 10));
    chk("acc_active", 128'(active_bank), 128'(0));

    // write tagged bank 0, swap while it is in flight
    wr(1, 1, v4(9, 9, 9, 9));
    sw();
    idle(2);
    rd(1);
    chk("inflight_old_bank", rdata, v4(9, 9, 9, 9));
    sw();
    rd(1);
    chk("inflight_new_bank", rdata, '0);

    // wrap-around, bank 0 entry 5
    wr(5, 1, v4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h5));
    wr(5, 0, v4(1, 1, 1, 32'hFFFF_FFF9));
    idle(3);
    sw();
    rd(5);
    chk("wrap", rdata, v4(32'h8000_0000, 32'h8000_0000, 0, 32'hFFFF_FFFE));

    // read and commit hit bank 1 entry 2 in the same cycle
    wr(2, 1, v4(4, 5, 6, 7));
    idle(3);
    wr(2, 0, v4(6, 6, 6, 6));
    sw();
    idle(1);
    rd(2);
    chk("collide_old", rdata, v4(4, 5, 6, 7));
    rd(2);
    chk("collide_new", rdata, v4(10, 11, 12, 13));

    // reset with two writes in flight
    sw();
    wr(7, 1, v4(3, 3, 3, 3));
    wr(8, 1, v4(3, 3, 3, 3));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_active", 128'(active_bank), 128'(0));
    chk("rst_rdata", rdata, '0);
    idle(4);
    rd(7);
    chk("rst_b1_e7", rdata, '0);
    rd(8);
    chk("rst_b1_e8", rdata, '0);
    rd(0);
    chk("rst_b1_e0", rdata, '0);
    rd(2);
    chk("rst_b1_e2", rdata, '0);
    sw();
    chk("rst_sw_active", 128'(active_bank), 128'(1));
    rd(3);
    chk("rst_b0_e3", rdata, '0);
    rd(5);
    chk("rst_b0_e5", rdata, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
